// File: rtl/imem_loader.sv
// Program loader for the MIPS single-cycle core: receives a counted, big-endian byte frame,
// writes the words to instruction memory from address 0 and holds the core in reset meanwhile.
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 8  // word-address width, at most 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  load_req,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   localparam logic [16:0] Depth = 17'(1) << ADDR_WIDTH;

   typedef enum logic [2:0] {
      StIdle,
      StHdrHi,
      StHdrLo,
      StData,
      StDone
   } state_e;

   state_e                  state_q, state_d;
   logic                    hs;
   logic                    enter_hdr, enter_done, last_byte;
   logic [15:0]             n_q, n_d;
   logic [1:0]              bcnt_q, bcnt_d;
   logic [23:0]             word_q, word_d;
   logic [15:0]             widx_q, widx_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    cpu_reset_q, cpu_reset_d;
   logic                    error_q, error_d;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign last_byte = (bcnt_q == 2'd3) && (widx_q == n_q - 16'd1);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  state_d = StHdrHi;
         StHdrHi: if (hs) state_d = StHdrLo;
         StHdrLo: if (hs) state_d = ({n_q[15:8], in_data} == 16'd0) ? StDone : StData;
         StData:  if (hs && last_byte) state_d = StDone;
         StDone:  if (load_req) state_d = StHdrHi;
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs
   always_comb begin
      in_ready = 1'b0;
      done     = 1'b0;
      case (state_q)
         StHdrHi, StHdrLo, StData: in_ready = 1'b1;
         StDone:                   done     = 1'b1;
         default: ;
      endcase
   end

   assign hs         = in_valid & in_ready;
   assign enter_hdr  = (state_q != StHdrHi) && (state_d == StHdrHi);
   assign enter_done = (state_q != StDone) && (state_d == StDone);

   // Datapath next state
   always_comb begin
      n_d         = n_q;
      bcnt_d      = bcnt_q;
      word_d      = word_q;
      widx_d      = widx_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_reset_d = cpu_reset_q;
      error_d     = error_q;

      if (enter_hdr) begin
         cpu_reset_d = 1'b1;
         error_d     = 1'b0;
         bcnt_d      = 2'd0;
         widx_d      = 16'd0;
      end

      if (state_q == StHdrHi && hs) begin
         n_d[15:8] = in_data;
      end

      if (state_q == StHdrLo && hs) begin
         n_d[7:0] = in_data;
         error_d  = ({1'b0, n_q[15:8], in_data} > Depth);
      end

      if (state_q == StData && hs) begin
         bcnt_d = bcnt_q + 2'd1;
         word_d = {word_q[15:0], in_data};
         if (bcnt_q == 2'd3) begin
            widx_d = widx_q + 16'd1;
            // Words past the end of memory are consumed but never written; addr holds.
            if ({1'b0, widx_q} < Depth) begin
               we_d    = 1'b1;
               addr_d  = widx_q[ADDR_WIDTH-1:0];
               wdata_d = {word_q, in_data};
            end
         end
      end

      // An overflowed image must not be executed, so the core stays in reset.
      if (enter_done) begin
         cpu_reset_d = error_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_q         <= 16'd0;
         bcnt_q      <= 2'd0;
         word_q      <= 24'd0;
         widx_q      <= 16'd0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         cpu_reset_q <= 1'b1;
         error_q     <= 1'b0;
      end else begin
         n_q         <= n_d;
         bcnt_q      <= bcnt_d;
         word_q      <= word_d;
         widx_q      <= widx_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
         error_q     <= error_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 256-word and a 4-word instance share one byte stream and are
// checked every cycle against a frame-position model, plus literal write/timing expectations.
module tb_imem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       load_req;

   logic        rdy_w, we_w, cr_w, done_w, err_w;
   logic [7:0]  addr_w;
   logic [31:0] wd_w;
   logic        rdy_n, we_n, cr_n, done_n, err_n;
   logic [1:0]  addr_n;
   logic [31:0] wd_n;

   imem_loader #(.ADDR_WIDTH(8)) dut_w (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_w),
      .load_req(load_req), .imem_we(we_w), .imem_addr(addr_w), .imem_wdata(wd_w),
      .cpu_reset(cr_w), .done(done_w), .error(err_w)
   );

   imem_loader #(.ADDR_WIDTH(2)) dut_n (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_n),
      .load_req(load_req), .imem_we(we_n), .imem_addr(addr_n), .imem_wdata(wd_n),
      .cpu_reset(cr_n), .done(done_n), .error(err_n)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Model: phase 0 idle, 1 header, 2 data, 3 done; position counts frame bytes consumed.
   int          m_phase, m_pos, m_n;
   logic [7:0]  m_frame [0:63];
   logic        ew_we, en_we;
   logic [7:0]  ew_addr;
   logic [1:0]  en_addr;
   logic [31:0] ew_data, en_data;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= 0;
         m_pos   <= 0;
         m_n     <= 0;
         ew_we   <= 1'b0;
         en_we   <= 1'b0;
         ew_addr <= 8'd0;
         en_addr <= 2'd0;
         ew_data <= 32'd0;
         en_data <= 32'd0;
      end else begin
         ew_we <= 1'b0;
         en_we <= 1'b0;
         case (m_phase)
            0: m_phase <= 1;
            1: if (in_valid) begin
               m_frame[m_pos] <= in_data;
               m_pos          <= m_pos + 1;
               if (m_pos == 1) begin
                  m_n     <= int'(m_frame[0]) * 256 + int'(in_data);
                  m_phase <= (m_frame[0] == 8'd0 && in_data == 8'd0) ? 3 : 2;
               end
            end
            2: if (in_valid) begin
               m_frame[m_pos] <= in_data;
               m_pos          <= m_pos + 1;
               if ((m_pos - 2) % 4 == 3) begin
                  if ((m_pos - 2) / 4 < 256) begin
                     ew_we   <= 1'b1;
                     ew_addr <= 8'((m_pos - 2) / 4);
                     ew_data <= {m_frame[m_pos-3], m_frame[m_pos-2], m_frame[m_pos-1], in_data};
                  end
                  if ((m_pos - 2) / 4 < 4) begin
                     en_we   <= 1'b1;
                     en_addr <= 2'((m_pos - 2) / 4);
                     en_data <= {m_frame[m_pos-3], m_frame[m_pos-2], m_frame[m_pos-1], in_data};
                  end
               end
               if (m_pos + 1 == 2 + 4 * m_n) m_phase <= 3;
            end
            3: if (load_req) begin
               m_phase <= 1;
               m_pos   <= 0;
            end
            default: ;
         endcase
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic xe_w, xe_n;
      if (!reset) begin
         chk("rst_w_ready", rdy_w, 0); chk("rst_w_we", we_w, 0); chk("rst_w_cpu_reset", cr_w, 1);
         chk("rst_n_ready", rdy_n, 0); chk("rst_n_we", we_n, 0); chk("rst_n_cpu_reset", cr_n, 1);
      end else begin
         xe_w = (m_phase >= 2) && (m_n > 256);
         xe_n = (m_phase >= 2) && (m_n > 4);
         chk("w_ready", rdy_w, (m_phase == 1 || m_phase == 2));
         chk("w_done", done_w, (m_phase == 3));
         chk("w_error", err_w, xe_w);
         chk("w_cpu_reset", cr_w, !(m_phase == 3 && !xe_w));
         chk("w_we", we_w, ew_we);
         chk("w_addr", addr_w, ew_addr);
         chk("w_wdata", wd_w, ew_data);
         chk("n_ready", rdy_n, (m_phase == 1 || m_phase == 2));
         chk("n_done", done_n, (m_phase == 3));
         chk("n_error", err_n, xe_n);
         chk("n_cpu_reset", cr_n, !(m_phase == 3 && !xe_n));
         chk("n_we", we_n, en_we);
         chk("n_addr", addr_n, en_addr);
         chk("n_wdata", wd_n, en_data);
      end
   end

   // Write logs for literal checks
   logic [31:0] lw_a[$], lw_d[$], ln_a[$], ln_d[$];
   always @(negedge clk) begin
      if (reset && we_w) begin lw_a.push_back(addr_w); lw_d.push_back(wd_w); end
      if (reset && we_n) begin ln_a.push_back(addr_n); ln_d.push_back(wd_n); end
   end

   logic [7:0] fr_a [10] = '{8'h00, 8'h02, 8'h00, 8'h62, 8'h18, 8'h20, 8'h00, 8'h63, 8'h38, 8'h22};

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!rdy_w && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready low for %0d cycles, want high", guard);
      end
      @(posedge clk);
   endtask

   task automatic gap(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic pulse_load();
      @(negedge clk);
      in_valid = 1'b0;
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      chk("load_cpu_reset", cr_w, 1);
      chk("load_done", done_w, 0);
      chk("load_ready", rdy_w, 1);
   endtask

   task automatic check_frame_a(input string tag, input int base);
      chk({tag, "_nwrites"}, lw_d.size() - base, 2);
      if (lw_d.size() >= base + 2) begin
         chk({tag, "_addr0"}, lw_a[base], 0);
         chk({tag, "_data0"}, lw_d[base], 32'h0062_1820);
         chk({tag, "_addr1"}, lw_a[base+1], 1);
         chk({tag, "_data1"}, lw_d[base+1], 32'h0063_3822);
      end
   endtask

   initial begin
      int base, nbase, t0;
      reset    = 1'b0;
      in_data  = 8'd0;
      in_valid = 1'b0;
      load_req = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk("idle_ready", rdy_w, 0);

      // Back-to-back stream
      base = lw_d.size();
      send_byte(fr_a[0]);
      t0 = cyc;
      for (int i = 1; i < 10; i++) send_byte(fr_a[i]);
      chk("t1_no_stall", cyc - t0, 9);
      #1;
      chk("t1_done", done_w, 1);
      chk("t1_cpu_reset", cr_w, 0);
      #6 check_frame_a("t1", base);

      // Same stream with bubbles and a 5-cycle gap mid-word
      pulse_load();
      base = lw_d.size();
      for (int i = 0; i < 10; i++) begin
         send_byte(fr_a[i]);
         if (i < 9) gap((i == 6) ? 5 : 1);
      end
      #1 chk("t2_done", done_w, 1);
      #6 check_frame_a("t2", base);

      // Empty program
      pulse_load();
      base = lw_d.size();
      send_byte(8'h00);
      send_byte(8'h00);
      #1;
      chk("t3_done", done_w, 1);
      chk("t3_cpu_reset", cr_w, 0);
      chk("t3_n_cpu_reset", cr_n, 0);
      #6 chk("t3_nwrites", lw_d.size() - base, 0);

      // Five words into a 4-word memory (narrow) and a 256-word memory (wide)
      pulse_load();
      base  = lw_d.size();
      nbase = ln_d.size();
      send_byte(8'h00);
      send_byte(8'h05);
      #1;
      chk("t4_n_error", err_n, 1);
      chk("t4_w_error", err_w, 0);
      for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
      #1;
      chk("t4_n_done", done_n, 1);
      chk("t4_n_cpu_reset", cr_n, 1);
      chk("t4_w_cpu_reset", cr_w, 0);
      #6;
      chk("t4_n_nwrites", ln_d.size() - nbase, 4);
      chk("t4_w_nwrites", lw_d.size() - base, 5);
      if (ln_d.size() >= nbase + 4) begin
         chk("t4_n_last_addr", ln_a[nbase+3], 3);
         chk("t4_n_last_data", ln_d[nbase+3], 32'h1c1d_1e1f);
      end
      if (lw_d.size() >= base + 5) begin
         chk("t4_w_last_addr", lw_a[base+4], 4);
         chk("t4_w_last_data", lw_d[base+4], 32'h2021_2223);
      end

      // Reload with a 1-word frame; load_req during DATA is ignored
      pulse_load();
      chk("t5_n_cpu_reset_high", cr_n, 1);
      base = lw_d.size();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h8c);
      send_byte(8'h04);
      @(negedge clk);
      in_valid = 1'b0;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      chk("t5_mid_ready", rdy_w, 1);
      send_byte(8'h00);
      send_byte(8'h04);
      #1;
      chk("t5_done", done_w, 1);
      chk("t5_cpu_reset", cr_w, 0);
      chk("t5_n_cpu_reset", cr_n, 0);
      #6;
      chk("t5_nwrites", lw_d.size() - base, 1);
      if (lw_d.size() >= base + 1) begin
         chk("t5_addr0", lw_a[base], 0);
         chk("t5_data0", lw_d[base], 32'h8c04_0004);
      end

      // Asynchronous reset after 3 bytes of the first data word
      pulse_load();
      for (int i = 0; i < 5; i++) send_byte(fr_a[i]);
      #2 reset = 1'b0;
      #1;
      chk("t6_ready", rdy_w, 0);
      chk("t6_we", we_w, 0);
      chk("t6_addr", addr_w, 0);
      chk("t6_wdata", wd_w, 0);
      chk("t6_cpu_reset", cr_w, 1);
      chk("t6_done", done_w, 0);
      chk("t6_error", err_w, 0);
      chk("t6_n_wdata", wd_n, 0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      base = lw_d.size();
      for (int i = 0; i < 10; i++) send_byte(fr_a[i]);
      #1 chk("t6_reload_done", done_w, 1);
      #6 check_frame_a("t6", base);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
